// File: rtl/alarm_controller_if.sv
// alarm_controller_if
// Groups the alarm controller's keypad/sensor inputs and its display/siren
// outputs into one bundle.
//   master : drives secondClock, armPulse, disarmPulse, sensorTrip;
//            observes state, secondsLeft, siren, armedLed
//   slave  : the alarm controller side (the opposite directions)
// countWidth sets the width of secondsLeft and must match the controller.
interface alarm_controller_if #(
    parameter int countWidth = 8
);
    logic                  secondClock;
    logic                  armPulse;
    logic                  disarmPulse;
    logic                  sensorTrip;
    logic [2:0]            state;
    logic [countWidth-1:0] secondsLeft;
    logic                  siren;
    logic                  armedLed;

    modport master (
        output secondClock, armPulse, disarmPulse, sensorTrip,
        input  state, secondsLeft, siren, armedLed
    );

    modport slave (
        input  secondClock, armPulse, disarmPulse, sensorTrip,
        output state, secondsLeft, siren, armedLed
    );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller
// Home-alarm sequencer. Turns the 1 Hz square wave into one-cycle second
// ticks and runs DISARMED -> EXIT_DELAY -> ARMED -> ENTRY_DELAY -> ALARM with
// per-second countdowns.
// Ports:
//   clockIn : system clock
//   reset   : synchronous, active-high
//   bus     : alarm_controller_if.slave
//             in : secondClock (1 Hz, same domain), armPulse, disarmPulse,
//                  sensorTrip (level)
//             out: state (3 bits), secondsLeft, siren, armedLed (registered)
module alarm_controller #(
    parameter int exitDelay     = 30,
    parameter int entryDelay    = 20,
    parameter int alarmDuration = 180,
    parameter int countWidth    = 8
) (
    input  logic              clockIn,
    input  logic              reset,
    alarm_controller_if.slave bus
);
    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_t;

    localparam logic [countWidth-1:0] ONE        = countWidth'(1);
    localparam logic [countWidth-1:0] EXIT_LOAD  = countWidth'(exitDelay);
    localparam logic [countWidth-1:0] ENTRY_LOAD = countWidth'(entryDelay);
    localparam logic [countWidth-1:0] ALARM_LOAD = countWidth'(alarmDuration);

    state_t                state_q;
    state_t                next_state;
    logic [countWidth-1:0] count_q;
    logic [countWidth-1:0] next_count;
    logic                  prev_second;
    logic                  tick;
    logic                  siren_q;
    logic                  led_q;

    // One-cycle pulse per rising edge of the slow clock.
    assign tick = bus.secondClock & ~prev_second;

    always_comb begin
        next_state = state_q;
        next_count = count_q;
        if (bus.disarmPulse) begin
            next_state = DISARMED;
            next_count = '0;
        end else begin
            case (state_q)
                DISARMED: begin
                    if (bus.armPulse) begin
                        next_state = EXIT_DELAY;
                        next_count = EXIT_LOAD;
                    end
                end
                EXIT_DELAY: begin
                    if (tick && count_q == ONE) begin
                        next_state = ARMED;
                        next_count = '0;
                    end else if (tick && count_q != '0) begin
                        next_count = count_q - ONE;
                    end
                end
                ARMED: begin
                    if (bus.sensorTrip) begin
                        next_state = ENTRY_DELAY;
                        next_count = ENTRY_LOAD;
                    end
                end
                ENTRY_DELAY: begin
                    if (tick && count_q == ONE) begin
                        next_state = ALARM;
                        next_count = ALARM_LOAD;
                    end else if (tick && count_q != '0) begin
                        next_count = count_q - ONE;
                    end
                end
                ALARM: begin
                    // Expiry always lands in ARMED first; a still-high sensor
                    // re-enters ENTRY_DELAY on the following cycle.
                    if (tick && count_q == ONE) begin
                        next_state = ARMED;
                        next_count = '0;
                    end else if (tick && count_q != '0) begin
                        next_count = count_q - ONE;
                    end
                end
                default: begin
                    // Codes 5-7 recover to a safe state.
                    next_state = DISARMED;
                    next_count = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clockIn) begin
        // Tracked through reset so the first post-reset cycle never ticks.
        prev_second <= bus.secondClock;
        if (reset) begin
            state_q <= DISARMED;
            count_q <= '0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= next_state;
            count_q <= next_count;
            siren_q <= (next_state == ALARM);
            case (next_state)
                EXIT_DELAY:               led_q <= bus.secondClock;
                ARMED, ENTRY_DELAY, ALARM: led_q <= 1'b1;
                default:                  led_q <= 1'b0;
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.secondsLeft = count_q;
    assign bus.siren       = siren_q;
    assign bus.armedLed    = led_q;
endmodule
